// File: rtl/funrv32_pkg.sv
// Shared constants and types for the funRV32 register file and the
// decode/writeback stages that talk to it.
package funrv32_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_X0    = 0;

  // Clear sequencer states: CLEAR zeroes one entry per cycle, RUN is normal operation.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } clr_state_e;

endpackage

// File: rtl/funrv32_regfile_if.sv
// Register file bus: writeback write port, decode read addresses, read data and ready.
interface funrv32_regfile_if
  import funrv32_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int AW    = 5,
  parameter int NREAD = 2
) ();

  logic                    ready;
  logic                    we;
  logic [AW-1:0]           ad;
  logic [XLEN-1:0]         rd;
  logic [NREAD*AW-1:0]     a;
  logic [NREAD*XLEN-1:0]   r;

  modport master (input ready, input r, output we, output ad, output rd, output a);
  modport slave  (output ready, output r, input we, input ad, input rd, input a);

endinterface

// File: rtl/funrv32_regfile_rdport.sv
// One read port: applies the zero / range / bypass rules and the optional
// output register.
module funrv32_regfile_rdport
  import funrv32_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREGS     = NREGS_DEF,
  parameter int AW        = 5,
  parameter int ZERO_X0   = 1,
  parameter int BYPASS    = 1,
  parameter int SYNC_READ = 0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_ready,
  input  logic [AW-1:0]   i_addr,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_we_eff,
  input  logic [AW-1:0]   i_wad,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_data
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic            w_in_range;
  logic            w_is_x0;
  logic            w_hit;
  logic [XLEN-1:0] w_val;
  logic [XLEN-1:0] r_data;

  // Resolve the port value: zero beats bypass, bypass beats storage.
  always_comb begin
    w_in_range = ({1'b0, i_addr} < NREGS_W);
    w_is_x0    = (ZERO_X0 != 0) && (i_addr == AW'(REG_X0));
    w_hit      = (BYPASS != 0) && i_we_eff && (i_wad == i_addr);
    if (!i_ready || !w_in_range || w_is_x0) begin
      w_val = '0;
    end else if (w_hit) begin
      w_val = i_wdata;
    end else begin
      w_val = i_mem_data;
    end
  end

  // Registered copy of the port value, forced to zero while reset is held.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data <= '0;
    end else begin
      r_data <= w_val;
    end
  end

  assign o_data = (SYNC_READ != 0) ? r_data : w_val;

endmodule

// File: rtl/funrv32_regfile.sv
// funRV32 integer register file: NREAD read ports, one write port, optional
// hardwired x0 and bypass. Storage has no reset; a clear sequencer zeroes it
// after every reset and raises ready when done.
module funrv32_regfile
  import funrv32_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREGS     = NREGS_DEF,
  parameter int NREAD     = 2,
  parameter int ZERO_X0   = 1,
  parameter int BYPASS    = 1,
  parameter int SYNC_READ = 0,
  localparam int AW       = $clog2(NREGS)
) (
  input logic              i_clk,
  input logic              i_reset,
  funrv32_regfile_if.slave bus
);

  localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

  clr_state_e      r_state;
  logic [AW-1:0]   r_cnt;
  logic            r_ready;
  logic [XLEN-1:0] r_mem [NREGS];
  logic            w_we_eff;
  logic            w_clr_we;
  logic [XLEN-1:0] w_rdata [NREAD];

  // Qualify the external write and the sequencer's clearing write.
  always_comb begin
    w_we_eff = bus.we & r_ready & ({1'b0, bus.ad} < NREGS_W)
             & ~((ZERO_X0 != 0) & (bus.ad == AW'(REG_X0)));
    w_clr_we = (r_state == ST_CLEAR) & ~i_reset;
  end

  // Clear sequencer: walk cnt over every entry, then hold RUN until reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_cnt == LAST) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + AW'(1);
          end
        end
        ST_RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage write: the clear sequencer owns the array until ready.
  always_ff @(posedge i_clk) begin
    if (w_clr_we) begin
      r_mem[r_cnt] <= '0;
    end else if (w_we_eff) begin
      r_mem[bus.ad] <= bus.rd;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   w_a;
    logic [XLEN-1:0] w_mem_q;
    assign w_a     = bus.a[i*AW +: AW];
    assign w_mem_q = ({1'b0, w_a} < NREGS_W) ? r_mem[w_a] : '0;

    funrv32_regfile_rdport #(
      .XLEN(XLEN), .NREGS(NREGS), .AW(AW),
      .ZERO_X0(ZERO_X0), .BYPASS(BYPASS), .SYNC_READ(SYNC_READ)
    ) u_rdport (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_ready    (r_ready),
      .i_addr     (w_a),
      .i_mem_data (w_mem_q),
      .i_we_eff   (w_we_eff),
      .i_wad      (bus.ad),
      .i_wdata    (bus.rd),
      .o_data     (w_rdata[i])
    );
  end

  // Pack the per-port results onto the bus.
  always_comb begin
    bus.r = '0;
    for (int i = 0; i < NREAD; i++) begin
      bus.r[i*XLEN +: XLEN] = w_rdata[i];
    end
  end

  assign bus.ready = r_ready;

endmodule
